// File: rtl/regfile_cmd_seq_pkg.sv
// Shared opcodes, sequencer state encoding and register-count helper
// for the register-file command sequencer.
package regfile_cmd_seq_pkg;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_WR   = 3'd1;
    localparam logic [2:0] OP_RD   = 3'd2;
    localparam logic [2:0] OP_MOVE = 3'd3;
    localparam logic [2:0] OP_SWAP = 3'd4;
    localparam logic [2:0] OP_CLR  = 3'd5;
    localparam logic [2:0] OP_ADD  = 3'd6;
    localparam logic [2:0] OP_ILL  = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_SWAP2,
        S_CLEAR,
        S_RESP
    } state_t;

    function automatic int num_regs(input int addsize);
        return 1 << addsize;
    endfunction

endpackage

// File: rtl/regfile_cmd_seq.sv
// Register-file command sequencer: turns handshaked commands into
// ra/rb/rw/wdat/wren cycles and returns one response per command.
module regfile_cmd_seq
    import regfile_cmd_seq_pkg::*;
#(
    parameter int BITSIZE = 16,
    parameter int ADDSIZE = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [2:0]         cmd_op,
    input  logic [ADDSIZE-1:0] cmd_a,
    input  logic [ADDSIZE-1:0] cmd_b,
    input  logic [BITSIZE-1:0] cmd_imm,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [BITSIZE-1:0] rsp_data,
    output logic               rsp_err,
    output logic [ADDSIZE-1:0] ra,
    output logic [ADDSIZE-1:0] rb,
    output logic [ADDSIZE-1:0] rw,
    output logic [BITSIZE-1:0] wdat,
    output logic               wren,
    input  logic [BITSIZE-1:0] adat,
    input  logic [BITSIZE-1:0] bdat
);

    localparam int NREGS = num_regs(ADDSIZE);
    localparam logic [ADDSIZE-1:0] LAST = ADDSIZE'(NREGS - 1);

    state_t             state;
    state_t             state_nx;
    logic [2:0]         op;
    logic [ADDSIZE-1:0] a;
    logic [ADDSIZE-1:0] b;
    logic [ADDSIZE-1:0] cnt;
    logic [BITSIZE-1:0] imm;
    logic [BITSIZE-1:0] hold_a;
    logic [BITSIZE-1:0] hold_b;
    logic               wr;
    logic               accept;

    assign cmd_ready = rst && (state == S_IDLE);
    assign rsp_valid = rst && (state == S_RESP);
    assign accept    = cmd_valid && cmd_ready;
    assign wren      = wr && rst;

    always_comb begin
        state_nx = state;
        ra       = '0;
        rb       = '0;
        rw       = '0;
        wdat     = '0;
        wr       = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (accept)
                    state_nx = (cmd_op == OP_CLR) ? S_CLEAR : S_EXEC;
            end
            S_EXEC: begin
                ra       = a;
                rb       = b;
                state_nx = (op == OP_SWAP) ? S_SWAP2 : S_RESP;
                case (op)
                    OP_WR:   begin wr = 1'b1; rw = a; wdat = imm;         end
                    OP_MOVE: begin wr = 1'b1; rw = b; wdat = adat;        end
                    OP_ADD:  begin wr = 1'b1; rw = a; wdat = adat + bdat; end
                    OP_SWAP: begin wr = 1'b1; rw = a; wdat = bdat;        end
                    default: ;
                endcase
            end
            S_SWAP2: begin
                wr       = 1'b1;
                rw       = b;
                wdat     = hold_a;
                state_nx = S_RESP;
            end
            S_CLEAR: begin
                wr = 1'b1;
                rw = cnt;
                if (cnt == LAST)
                    state_nx = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready)
                    state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    // Response is derived from the values captured in EXEC, so it stays
    // stable for as long as the consumer stalls.
    always_comb begin
        rsp_data = '0;
        rsp_err  = 1'b0;
        if (state == S_RESP) begin
            case (op)
                OP_WR:   rsp_data = imm;
                OP_RD:   rsp_data = hold_a;
                OP_MOVE: rsp_data = hold_a;
                OP_SWAP: rsp_data = hold_a;
                OP_ADD:  rsp_data = hold_a + hold_b;
                OP_ILL:  rsp_err  = 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            op     <= OP_NOP;
            a      <= '0;
            b      <= '0;
            imm    <= '0;
            cnt    <= '0;
            hold_a <= '0;
            hold_b <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op  <= cmd_op;
                a   <= cmd_a;
                b   <= cmd_b;
                imm <= cmd_imm;
                cnt <= '0;
            end
            if (state == S_EXEC) begin
                hold_a <= adat;
                hold_b <= bdat;
            end
            if (state == S_CLEAR)
                cnt <= cnt + 1'b1;
        end
    end

endmodule
